// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event pulses into fixed-width LED flashes.
// Each flash lasts ON_COUNT cycles and is followed by a forced GAP_COUNT-cycle
// low period. Events arriving while busy are counted in a saturating pending
// counter and replayed back to back. Dropped events raise a one-cycle overflow.
module pulse_stretcher #(
   parameter int unsigned ON_COUNT  = 4095,
   parameter int unsigned GAP_COUNT = 2047,
   parameter int unsigned PEND_W    = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pulse_in,
   output logic              led_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ON,
      ST_GAP
   } state_e;

   // Counters hold "cycles remaining minus one", so a phase ends when the
   // counter reads zero and the next phase is loaded at that same edge.
   localparam logic [11:0]       ON_RELOAD  = 12'(ON_COUNT - 1);
   localparam logic [11:0]       GAP_RELOAD = 12'(GAP_COUNT - 1);
   localparam logic [PEND_W-1:0] PEND_MAX   = '1;
   localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);

   state_e            state_q, state_d;
   logic [11:0]       cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              led_q, led_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;

   logic              cnt_zero;
   logic              inc;
   logic              dec;

   assign cnt_zero = (cnt_q == 12'd0);
   // Every high cycle of pulse_in while busy is a new event to be queued,
   // including the last gap cycle, where it may cancel against the replay.
   assign inc      = pulse_in && (state_q != ST_IDLE);

   // Phase sequencing: IDLE -> ON -> GAP -> (ON again if work is queued | IDLE).
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      dec     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pulse_in) begin
               state_d = ST_ON;
               cnt_d   = ON_RELOAD;
            end
         end

         ST_ON: begin
            if (cnt_zero) begin
               state_d = ST_GAP;
               cnt_d   = GAP_RELOAD;
            end else begin
               cnt_d = cnt_q - 12'd1;
            end
         end

         ST_GAP: begin
            if (cnt_zero) begin
               if ((pend_q != '0) || pulse_in) begin
                  // Replay one event; a pulse on this very cycle is served
                  // directly when nothing is queued (inc and dec cancel).
                  state_d = ST_ON;
                  cnt_d   = ON_RELOAD;
                  dec     = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 12'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 12'd0;
         end
      endcase
   end

   // Pending-event bookkeeping: saturating up/down counter with drop detection.
   always_comb begin
      pend_d = pend_q;
      ovf_d  = 1'b0;

      case ({inc, dec})
         2'b10: begin
            if (pend_q == PEND_MAX) begin
               ovf_d = 1'b1;
            end else begin
               pend_d = pend_q + PEND_ONE;
            end
         end
         2'b01:   pend_d = pend_q - PEND_ONE;
         default: pend_d = pend_q;
      endcase
   end

   // Outputs are decoded from the next state so they come straight off flops.
   always_comb begin
      led_d  = (state_d == ST_ON);
      busy_d = (state_d != ST_IDLE);
   end

   // State register; an asserted reset abandons any flash and queued events.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 12'd0;
         pend_q  <= '0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // values computed from the previous state, independent of order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign led_out  = led_q;
   assign busy     = busy_q;
   assign pending  = pend_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher. A small-parameter instance is
// checked by an event scoreboard: each test pushes the output transitions it
// expects (cycle, signal, new value) and an independent monitor compares every
// observed output change against the queue head. A default-parameter instance
// checks the full-length flash and gap.
module tb_pulse_stretcher;

   localparam int HALF = 100;  // 5 MHz clock
   localparam int PW   = 2;

   logic          clock    = 1'b0;
   logic          reset    = 1'b0;
   logic          pulse_in = 1'b0;
   logic          led_out;
   logic          busy;
   logic [PW-1:0] pending;
   logic          overflow;

   logic          pulse2 = 1'b0;
   logic          led2;
   logic          busy2;
   logic [2:0]    pend2;
   logic          ovf2;

   int cyc      = 0;
   int t0       = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef enum int {EV_LED = 1, EV_BUSY = 2, EV_PEND = 3, EV_OVF = 4} ev_kind_e;
   typedef struct {
      int       cyc;
      ev_kind_e kind;
      int       value;
   } ev_t;

   ev_t exp_q[$];

   pulse_stretcher #(.ON_COUNT(4), .GAP_COUNT(2), .PEND_W(PW)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .pulse_in (pulse_in),
      .led_out  (led_out),
      .busy     (busy),
      .pending  (pending),
      .overflow (overflow)
   );

   pulse_stretcher u_dflt (
      .clock    (clock),
      .reset    (reset),
      .pulse_in (pulse2),
      .led_out  (led2),
      .busy     (busy2),
      .pending  (pend2),
      .overflow (ovf2)
   );

   always #HALF clock = ~clock;

   // Cycle n is the interval following rising edge n.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   // Event codes read as cycle*100 + kind*10 + value.
   task automatic push(input int c, input ev_kind_e k, input int v);
      ev_t e;
      e.cyc   = t0 + c;
      e.kind  = k;
      e.value = v;
      exp_q.push_back(e);
   endtask

   task automatic cmp_event(input ev_kind_e k, input int v);
      ev_t e;
      if (exp_q.size() == 0) begin
         check($sformatf("unexpected %s change", k.name()), cyc * 100 + int'(k) * 10 + v, 0);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("event %s@%0d", e.kind.name(), e.cyc - t0),
               cyc * 100 + int'(k) * 10 + v,
               e.cyc * 100 + int'(e.kind) * 10 + e.value);
      end
   endtask

   task automatic start_test();
      @(negedge clock);
      t0 = cyc;
   endtask

   task automatic goto(input int n);
      while (cyc - t0 < n) @(negedge clock);
   endtask

   // Monitor: report every output transition of the small instance.
   initial begin
      logic p_led, p_busy, p_ovf;
      int   p_pend;
      p_led  = 1'b0;
      p_busy = 1'b0;
      p_ovf  = 1'b0;
      p_pend = 0;
      forever begin
         @(negedge clock);
         if (led_out !== p_led) begin
            cmp_event(EV_LED, int'(led_out));
            p_led = led_out;
         end
         if (busy !== p_busy) begin
            cmp_event(EV_BUSY, int'(busy));
            p_busy = busy;
         end
         if (int'(pending) !== p_pend) begin
            cmp_event(EV_PEND, int'(pending));
            p_pend = int'(pending);
         end
         if (overflow !== p_ovf) begin
            cmp_event(EV_OVF, int'(overflow));
            p_ovf = overflow;
         end
      end
   end

   initial begin
      int n_on;
      int n_gap;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst led_out", int'(led_out), 0);
      check("rst busy", int'(busy), 0);
      check("rst pending", int'(pending), 0);
      check("rst overflow", int'(overflow), 0);
      check("rst dflt busy", int'(busy2), 0);
      reset = 1'b1;

      // Single pulse at 10
      start_test();
      push(11, EV_LED, 1); push(11, EV_BUSY, 1);
      push(15, EV_LED, 0); push(17, EV_BUSY, 0);
      goto(10); pulse_in = 1'b1; goto(11); pulse_in = 1'b0;
      goto(20);

      // Pulses at 10 and 12
      start_test();
      push(11, EV_LED, 1); push(11, EV_BUSY, 1); push(13, EV_PEND, 1);
      push(15, EV_LED, 0); push(17, EV_LED, 1); push(17, EV_PEND, 0);
      push(21, EV_LED, 0); push(23, EV_BUSY, 0);
      goto(10); pulse_in = 1'b1; goto(11); pulse_in = 1'b0;
      goto(12); pulse_in = 1'b1; goto(13); pulse_in = 1'b0;
      goto(26);

      // Five consecutive pulses 10..14: saturation and overflow
      start_test();
      push(11, EV_LED, 1); push(11, EV_BUSY, 1);
      push(12, EV_PEND, 1); push(13, EV_PEND, 2); push(14, EV_PEND, 3);
      push(15, EV_LED, 0); push(15, EV_OVF, 1); push(16, EV_OVF, 0);
      push(17, EV_LED, 1); push(17, EV_PEND, 2); push(21, EV_LED, 0);
      push(23, EV_LED, 1); push(23, EV_PEND, 1); push(27, EV_LED, 0);
      push(29, EV_LED, 1); push(29, EV_PEND, 0); push(33, EV_LED, 0);
      push(35, EV_BUSY, 0);
      goto(10); pulse_in = 1'b1; goto(15); pulse_in = 1'b0;
      goto(40);

      // Pulse exactly on the final gap cycle
      start_test();
      push(11, EV_LED, 1); push(11, EV_BUSY, 1); push(15, EV_LED, 0);
      push(17, EV_LED, 1); push(21, EV_LED, 0); push(23, EV_BUSY, 0);
      goto(10); pulse_in = 1'b1; goto(11); pulse_in = 1'b0;
      goto(16); pulse_in = 1'b1; goto(17); pulse_in = 1'b0;
      goto(26);

      // Asynchronous reset mid-flash with two events queued
      start_test();
      push(11, EV_LED, 1); push(11, EV_BUSY, 1);
      push(12, EV_PEND, 1); push(13, EV_PEND, 2);
      push(14, EV_LED, 0); push(14, EV_BUSY, 0); push(14, EV_PEND, 0);
      goto(10); pulse_in = 1'b1; goto(13); pulse_in = 1'b0;
      @(posedge clock);
      #(HALF / 2);
      check("pre-reset pending", int'(pending), 2);
      reset = 1'b0;
      #10;
      check("async rst led_out", int'(led_out), 0);
      check("async rst busy", int'(busy), 0);
      check("async rst pending", int'(pending), 0);
      goto(16); reset = 1'b1;
      push(21, EV_LED, 1); push(21, EV_BUSY, 1);
      push(25, EV_LED, 0); push(27, EV_BUSY, 0);
      goto(20); pulse_in = 1'b1; goto(21); pulse_in = 1'b0;
      goto(30);

      begin : drain
         int waited;
         waited = 0;
         while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clock);
            waited++;
         end
      end
      check("scoreboard drained", exp_q.size(), 0);

      // Default parameters: 4095-cycle flash, 2047-cycle gap
      @(negedge clock);
      pulse2 = 1'b1;
      @(negedge clock);
      pulse2 = 1'b0;
      n_on = 0;
      while (led2 === 1'b1 && n_on < 5000) begin
         n_on++;
         @(negedge clock);
      end
      n_gap = 0;
      while (busy2 === 1'b1 && led2 === 1'b0 && n_gap < 3000) begin
         n_gap++;
         @(negedge clock);
      end
      check("dflt on cycles", n_on, 4095);
      check("dflt gap cycles", n_gap, 2047);
      check("dflt idle busy", int'(busy2), 0);
      check("dflt idle led", int'(led2), 0);
      check("dflt pending", int'(pend2), 0);
      check("dflt overflow", int'(ovf2), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
